hazard_ctrl: RTL

Pipeline hazard controller for the five-stage core. It sits beside the decode/execute pipeline register and drives its Stall/Flush inputs, along with the fetch, execute and memory stage enables. It generates operand-forwarding selects for the execute stage. A small FSM freezes the whole pipeline during data-cache miss refills and sequences the refill handshake.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_ctrl_forward_sel.sv | 23 ++
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Holds the refill FSM states, the load result-select code and the forwarding selects.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MISS   = 2'd1,
    RESUME = 2'd2
  } state_e;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // x0 is hardwired to zero, so it never carries a dependency.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_forward_sel.sv
// Operand-forwarding select for one execute-stage source register.
// The memory-stage result is younger, so it wins over writeback.
module forward_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && reg_match(rd_m_i, rs_e_i)) begin
      fwd_o = FWD_M;
    end else if (reg_write_w_i && reg_match(rd_w_i, rs_e_i)) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, operand forwarding,
// and a refill FSM that freezes the pipeline while a data-cache miss is serviced.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemAccessM,
  input  logic             HitM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             StallE,
  output logic             StallM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             RefillReq,
  output logic [CNT_W-1:0] stall_cycles
);

  state_e           state_q, state_d;
  logic             miss_detect;
  logic             freeze;
  logic             lw_stall;
  logic             refill_d, refill_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign miss_detect = MemAccessM && !HitM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (miss_detect) state_d = MISS;
      MISS:    if (MemReadyM) state_d = RESUME;
      RESUME:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // RESUME lets the refilled access complete, so a miss seen there is not a new miss.
  always_comb begin
    freeze = 1'b0;
    unique case (state_q)
      RUN:     freeze = miss_detect;
      MISS:    freeze = 1'b1;
      RESUME:  freeze = 1'b0;
      default: freeze = 1'b0;
    endcase
    refill_d = (state_d == MISS);
  end

  always_comb begin
    lw_stall = (ResultSrcE == RESULT_LOAD) &&
               (reg_match(RdE, Rs1D) || reg_match(RdE, Rs2D));
  end

  // A branch resolved while frozen stays in the held execute register and
  // flushes on the first unfrozen cycle.
  always_comb begin
    StallF = lw_stall | freeze;
    StallD = lw_stall | freeze;
    StallE = freeze;
    StallM = freeze;
    FlushD = PCSrcE & ~freeze;
    FlushE = (PCSrcE | lw_stall) & ~freeze;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refill_q <= 1'b0;
    end else begin
      refill_q <= refill_d;
    end
  end

  assign RefillReq = refill_q;

  always_comb begin
    cnt_d = cnt_q;
    if (StallF && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

  forward_sel u_fwd_a (
    .rs_e_i        (Rs1E),
    .rd_m_i        (RdM),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RdW),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (ForwardAE)
  );

  forward_sel u_fwd_b (
    .rs_e_i        (Rs2E),
    .rd_m_i        (RdM),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RdW),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (ForwardBE)
  );

endmodule
